// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_tx_arbiter_if : requester byte channels plus the shared uart_tx port |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
interface uart_tx_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
);
   logic [NUM_REQ-1:0]   req_valid;
   logic [8*NUM_REQ-1:0] req_data;
   logic [NUM_REQ-1:0]   req_last;
   logic [NUM_REQ-1:0]   req_ready;
   logic [7:0]           tx_data;
   logic                 tx_data_valid;
   logic                 tx_data_ready;
   logic [ID_W-1:0]      grant_id;
   logic                 busy;
   logic                 timeout_pulse;

   modport master (
      input  req_valid, req_data, req_last, tx_data_ready,
      output req_ready, tx_data, tx_data_valid, grant_id, busy, timeout_pulse
   );

   modport slave (
      output req_valid, req_data, req_last, tx_data_ready,
      input  req_ready, tx_data, tx_data_valid, grant_id, busy, timeout_pulse
   );
endinterface
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_tx_arbiter : packet-locked round-robin share of the uart_tx channel  |
// | UART_ARB_FIXED_PRIO_EN selects lowest-index-wins arbitration. Rev 1.0     |
// +--------------------------------------------------------------------------+
module uart_tx_arbiter #(
   parameter int NUM_REQ      = 4,
   parameter int LOCK_TIMEOUT = 1024,
   parameter int ID_W         = 2
) (
   input wire logic          clk_in,
   input wire logic          rst_n,
   uart_tx_arbiter_if.master bus
);
   localparam int               CNT_W    = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = (LOCK_TIMEOUT > 0) ? CNT_W'(LOCK_TIMEOUT - 1) : '0;
   localparam logic [CNT_W-1:0] CNT_MAX  = '1;
   localparam logic [ID_W-1:0]  ID_LAST  = ID_W'(NUM_REQ - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_SEND = 2'd1;
   localparam logic [1:0] S_HOLD = 2'd2;

   logic [1:0]         state_q, state_d;
   logic [7:0]         tx_data_q, tx_data_d;
   logic               tx_valid_q, tx_valid_d;
   logic               last_q, last_d;
   logic [ID_W-1:0]    grant_q, grant_d;
   logic               busy_q, busy_d;
   logic               tout_q, tout_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;

   logic               release_pkt;
   logic [ID_W-1:0]    rr_base;
   logic [ID_W-1:0]    cand;
   logic [ID_W-1:0]    win_idx;
   logic               win_found;
   logic [ID_W-1:0]    sel_idx;
   logic               accept;
   logic [7:0]         sel_data;
   logic               sel_last;
   logic [NUM_REQ-1:0] req_ready_w;

`ifdef UART_ARB_FIXED_PRIO_EN
   assign rr_base = '0;
`else
   logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;

   // The pointer moves past the owner only when its lock ends.
   assign rr_ptr_d = release_pkt ? ((grant_q == ID_LAST) ? '0 : grant_q + ID_W'(1)) : rr_ptr_q;

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_q <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
      end
   end

   assign rr_base = rr_ptr_q;
`endif

   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand = (int'(rr_base) + k >= NUM_REQ) ? ID_W'(int'(rr_base) + k - NUM_REQ)
                                              : ID_W'(int'(rr_base) + k);
         if (!win_found && bus.req_valid[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   // In HOLD only the owner may transfer; other requesters are ignored.
   assign sel_idx  = (state_q == S_IDLE) ? win_idx : grant_q;
   assign accept   = ((state_q == S_IDLE) && win_found) ||
                     ((state_q == S_HOLD) && bus.req_valid[grant_q]);
   assign sel_data = bus.req_data[{sel_idx, 3'b000} +: 8];
   assign sel_last = bus.req_last[sel_idx];

   always_comb begin
      req_ready_w          = '0;
      req_ready_w[sel_idx] = accept;
   end

   assign bus.req_ready = req_ready_w;

   always_comb begin
      state_d     = state_q;
      tx_data_d   = tx_data_q;
      tx_valid_d  = tx_valid_q;
      last_d      = last_q;
      grant_d     = grant_q;
      busy_d      = busy_q;
      tout_d      = 1'b0;
      cnt_d       = cnt_q;
      release_pkt = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (accept) begin
               tx_data_d  = sel_data;
               last_d     = sel_last;
               grant_d    = sel_idx;
               tx_valid_d = 1'b1;
               busy_d     = 1'b1;
               state_d    = S_SEND;
            end
         end
         S_SEND: begin
            if (bus.tx_data_ready) begin
               tx_valid_d = 1'b0;
               if (last_q) begin
                  state_d     = S_IDLE;
                  busy_d      = 1'b0;
                  release_pkt = 1'b1;
               end else begin
                  state_d = S_HOLD;
                  cnt_d   = '0;
               end
            end
         end
         S_HOLD: begin
            // An owner byte arriving on the timeout cycle takes precedence.
            if (accept) begin
               tx_data_d  = sel_data;
               last_d     = sel_last;
               grant_d    = sel_idx;
               tx_valid_d = 1'b1;
               cnt_d      = '0;
               state_d    = S_SEND;
            end else if ((LOCK_TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
               tout_d      = 1'b1;
               release_pkt = 1'b1;
               busy_d      = 1'b0;
               state_d     = S_IDLE;
            end else if (cnt_q != CNT_MAX) begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            state_d    = S_IDLE;
            busy_d     = 1'b0;
            tx_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         tx_data_q  <= 8'h00;
         tx_valid_q <= 1'b0;
         last_q     <= 1'b0;
         grant_q    <= '0;
         busy_q     <= 1'b0;
         tout_q     <= 1'b0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         tx_data_q  <= tx_data_d;
         tx_valid_q <= tx_valid_d;
         last_q     <= last_d;
         grant_q    <= grant_d;
         busy_q     <= busy_d;
         tout_q     <= tout_d;
         cnt_q      <= cnt_d;
      end
   end

   assign bus.tx_data       = tx_data_q;
   assign bus.tx_data_valid = tx_valid_q;
   assign bus.grant_id      = grant_q;
   assign bus.busy          = busy_q;
   assign bus.timeout_pulse = tout_q;
endmodule
`default_nettype wire
